string_printer: RTL

STRING_PRINTER -- requirements
Module: string_printer

---
 rtl/string_printer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/string_printer.sv
`default_nettype none
// ============================================================================
// Module   : string_printer
// Brief    : Walks a NUL-terminated string in word memory and streams its bytes
//            out over a valid/ready character interface.
// Options  : define STRING_PRINTER_NEWLINE_EN to append 0x0A after each string.
// Revision : 1.0 - initial release
// ============================================================================
module string_printer #(
   parameter int unsigned MAX_CHARS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] start_addr,
   output logic [31:0] mem_rd_addr,
   input  logic [31:0] mem_rd_data,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] char_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EMIT  = 2'd2
`ifdef STRING_PRINTER_NEWLINE_EN
      , S_NL  = 2'd3
`endif
   } state_t;

`ifdef STRING_PRINTER_NEWLINE_EN
   localparam state_t c_finish_state = S_NL;
   localparam logic   c_finish_done  = 1'b0;
`else
   localparam state_t c_finish_state = S_IDLE;
   localparam logic   c_finish_done  = 1'b1;
`endif

   localparam logic [16:0] c_max_chars = 17'(MAX_CHARS);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_addr;
   logic [31:0] r_word;
   logic [1:0]  r_index;
   logic [15:0] r_char_count;
   logic        r_done;

   logic        w_done_nxt;
   logic        w_load;
   logic        w_capture;
   logic        w_count_inc;
   logic        w_next_word;
   logic        w_next_byte;
   logic [7:0]  w_byte;
   logic [16:0] w_count_plus;
   logic        w_unused_addr_bits;

   assign w_unused_addr_bits = &{1'b0, start_addr[1:0]};
   assign w_count_plus       = {1'b0, r_char_count} + 17'd1;
   assign done               = r_done;
   assign char_count         = r_char_count;

   // Big-endian byte lanes: index 0 is the most significant byte.
   always_comb begin
      w_byte = 8'h00;
      case (r_index)
         2'd0:    w_byte = r_word[31:24];
         2'd1:    w_byte = r_word[23:16];
         2'd2:    w_byte = r_word[15:8];
         default: w_byte = r_word[7:0];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_count_inc = 1'b0;
      w_next_word = 1'b0;
      w_next_byte = 1'b0;
      mem_rd_addr = 32'h0;
      char_valid  = 1'b0;
      char_data   = 8'h00;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            // A start coinciding with the done cycle is deliberately not taken.
            if (start && !r_done) begin
               w_load      = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_rd_addr = r_addr;
            w_capture   = 1'b1;
            w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (w_byte == 8'h00) begin
               w_state_nxt = c_finish_state;
               w_done_nxt  = c_finish_done;
            end else begin
               char_valid = 1'b1;
               char_data  = w_byte;
               if (char_ready) begin
                  w_count_inc = 1'b1;
                  if (w_count_plus == c_max_chars) begin
                     w_state_nxt = c_finish_state;
                     w_done_nxt  = c_finish_done;
                  end else if (r_index == 2'd3) begin
                     w_next_word = 1'b1;
                     w_state_nxt = S_FETCH;
                  end else begin
                     w_next_byte = 1'b1;
                  end
               end
            end
         end
`ifdef STRING_PRINTER_NEWLINE_EN
         S_NL: begin
            char_valid = 1'b1;
            char_data  = 8'h0A;
            if (char_ready) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_done       <= 1'b0;
         r_addr       <= 32'h0;
         r_word       <= 32'h0;
         r_index      <= 2'd0;
         r_char_count <= 16'h0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         if (w_load) begin
            r_addr       <= {start_addr[31:2], 2'b00};
            r_index      <= 2'd0;
            r_char_count <= 16'h0;
         end
         if (w_capture) begin
            r_word <= mem_rd_data;
         end
         if (w_count_inc) begin
            r_char_count <= r_char_count + 16'd1;
         end
         if (w_next_word) begin
            r_addr  <= r_addr + 32'd4;
            r_index <= 2'd0;
         end else if (w_next_byte) begin
            r_index <= r_index + 2'd1;
         end
      end
   end

endmodule
`default_nettype wire
